// File: rtl/sobel_pkg.sv
// Shared widths, the 3x3 window type and the saturating radicand helper
// for the Sobel gradient-energy front end.
package sobel_pkg;
  localparam int PIX_W  = 8;
  localparam int GRAD_W = 11;
  localparam int SSQ_W  = 21;
  localparam int R_W    = 16;

  // Window indexed [row][col]: row 0 is the oldest row, col 0 the oldest column.
  typedef logic [2:0][2:0][PIX_W-1:0] win_t;

  function automatic logic [R_W-1:0] sat_r(input logic [SSQ_W-1:0] ssq,
                                           input int unsigned shift);
    logic [SSQ_W-1:0] r;
    r = ssq >> shift;
    if (r > SSQ_W'(17'h0FFFF)) return '1;
    return r[R_W-1:0];
  endfunction
endpackage

// File: rtl/sobel_grad_energy_if.sv
// Pixel-in / radicand-out stream bundle of the Sobel gradient-energy stage.
interface sobel_grad_energy_if;
  import sobel_pkg::*;

  // Both streams: a transfer happens on a rising edge where valid & ready are
  // both high; the source holds its payload stable while valid & !ready.
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pix;
  logic             in_sof;
  logic             out_valid;
  logic             out_ready;
  logic [R_W-1:0]   out_R;
  logic             out_last;

  modport slave (
    input  in_valid, in_pix, in_sof, out_ready,
    output in_ready, out_valid, out_R, out_last
  );

  modport master (
    output in_valid, in_pix, in_sof, out_ready,
    input  in_ready, out_valid, out_R, out_last
  );
endinterface

// File: rtl/sobel_line_buf.sv
// One-row pixel delay: read-before-write RAM addressed by column, so dout
// returns the pixel written at the same column one row earlier.
module sobel_line_buf
  import sobel_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [PIX_W-1:0]         din,
  output logic [PIX_W-1:0]         dout
);
  logic [PIX_W-1:0] mem_q [DEPTH];

  assign dout = mem_q[addr];

  always_ff @(posedge clk) begin
    if (en) mem_q[addr] <= din;
  end
endmodule

// File: rtl/sobel_grad_energy.sv
// Streaming Sobel front end: 3x3 window from two line buffers, Gx/Gy stage,
// then saturated (Gx^2+Gy^2)>>SHIFT with a stall-everything handshake.
module sobel_grad_energy
  import sobel_pkg::*;
#(
  parameter int          IMG_W = 256,
  parameter int          IMG_H = 256,
  parameter int unsigned SHIFT = 4
) (
  input  logic                clk,
  input  logic                rst,
  sobel_grad_energy_if.slave  bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  win_t          win_q, win_d;
  logic          v0_q, v0_d, last0_q, last0_d;
  logic          v1_q, v1_d, last1_q, last1_d;
  logic signed [GRAD_W-1:0] gx_q, gx_d, gy_q, gy_d;
  logic          out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [R_W-1:0] out_r_q, out_r_d;

  logic en, acc;
  logic [PIX_W-1:0] tap1, tap2;
  logic [9:0] gx_pos, gx_neg, gy_pos, gy_neg;
  logic signed [2*GRAD_W-1:0] gx_sq, gy_sq;
  logic [SSQ_W-1:0] ssq;

  // The output register is the only place a stall originates; everything
  // upstream freezes with it so no transfer is lost or duplicated.
  assign en      = !out_valid_q | bus.out_ready;
  assign acc     = bus.in_valid & en;
  assign cur_col = bus.in_sof ? '0 : col_q;
  assign cur_row = bus.in_sof ? '0 : row_q;

  sobel_line_buf #(.DEPTH(IMG_W)) u_lb1 (
    .clk(clk), .en(acc), .addr(cur_col), .din(bus.in_pix), .dout(tap1)
  );
  sobel_line_buf #(.DEPTH(IMG_W)) u_lb2 (
    .clk(clk), .en(acc), .addr(cur_col), .din(tap1), .dout(tap2)
  );

  assign gx_pos = 10'(win_q[0][2]) + {1'b0, win_q[1][2], 1'b0} + 10'(win_q[2][2]);
  assign gx_neg = 10'(win_q[0][0]) + {1'b0, win_q[1][0], 1'b0} + 10'(win_q[2][0]);
  assign gy_pos = 10'(win_q[2][0]) + {1'b0, win_q[2][1], 1'b0} + 10'(win_q[2][2]);
  assign gy_neg = 10'(win_q[0][0]) + {1'b0, win_q[0][1], 1'b0} + 10'(win_q[0][2]);
  assign gx_sq  = gx_q * gx_q;
  assign gy_sq  = gy_q * gy_q;
  assign ssq    = SSQ_W'(gx_sq) + SSQ_W'(gy_sq);

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    win_d       = win_q;
    v0_d        = v0_q;
    last0_d     = last0_q;
    v1_d        = v1_q;
    last1_d     = last1_q;
    gx_d        = gx_q;
    gy_d        = gy_q;
    out_valid_d = out_valid_q;
    out_r_d     = out_r_q;
    out_last_d  = out_last_q;
    if (en) begin
      if (acc) begin
        col_d = (cur_col == COL_MAX) ? '0 : cur_col + 1'b1;
        if (cur_col == COL_MAX) row_d = (cur_row == ROW_MAX) ? '0 : cur_row + 1'b1;
        else                    row_d = cur_row;
        for (int r = 0; r < 3; r++) begin
          win_d[r][0] = win_q[r][1];
          win_d[r][1] = win_q[r][2];
        end
        win_d[0][2] = tap2;
        win_d[1][2] = tap1;
        win_d[2][2] = bus.in_pix;
      end
      // Rows 0/1 read stale line-buffer contents; the window gate masks them.
      v0_d    = acc & (cur_row >= RW'(2)) & (cur_col >= CW'(2));
      last0_d = acc & (cur_row == ROW_MAX) & (cur_col == COL_MAX);
      v1_d    = v0_q;
      last1_d = last0_q;
      if (v0_q) begin
        gx_d = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
        gy_d = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});
      end
      out_valid_d = v1_q;
      if (v1_q) begin
        out_r_d    = sat_r(ssq, SHIFT);
        out_last_d = last1_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      v0_q        <= 1'b0;
      last0_q     <= 1'b0;
      v1_q        <= 1'b0;
      last1_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      v0_q        <= v0_d;
      last0_q     <= last0_d;
      v1_q        <= v1_d;
      last1_q     <= last1_d;
      out_valid_q <= out_valid_d;
      out_r_q     <= out_r_d;
      out_last_q  <= out_last_d;
    end
  end

  always_ff @(posedge clk) begin
    win_q <= win_d;
    gx_q  <= gx_d;
    gy_q  <= gy_d;
  end

  assign bus.in_ready  = en;
  assign bus.out_valid = out_valid_q;
  assign bus.out_R     = out_r_q;
  assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_sobel_grad_energy.sv
// Bench for sobel_grad_energy: frames driven pixel by pixel, expected results
// from a direct image-convolution model, checked by an independent monitor.
module tb_sobel_grad_energy;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int SH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sobel_grad_energy_if bus();

  sobel_grad_energy #(.IMG_W(W), .IMG_H(H), .SHIFT(SH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- scoreboard state ----------------
  int          img [H][W];
  logic [16:0] exp_q[$];           // {last, R}
  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  int rdy_mode = 0;
  bit gap_en   = 1'b0;
  bit tput_arm = 1'b0;
  int t22      = -1;
  int first_v  = -1;
  int out_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Reference: Sobel taken straight from the image around (r,c), (r,c) being
  // the bottom-right corner of the 3x3 neighbourhood.
  function automatic logic [16:0] model(input int r, input int c);
    int gx, gy, e;
    gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
       - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
    gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
       - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
    e = (gx*gx + gy*gy) >> SH;
    if (e > 65535) e = 65535;
    return {(r == H-1 && c == W-1), 16'(e)};
  endfunction

  task automatic fill_frame(input int mode, input int k);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (mode)
          0:       img[r][c] = 100;
          1:       img[r][c] = (c < 4) ? 0 : 255;
          2:       img[r][c] = (r + c >= k) ? 255 : 0;
          default: img[r][c] = int'($urandom_range(0, 255));
        endcase
  endtask

  // ---------------- driver ----------------
  task automatic send_pix(input int pix, input bit sof, input int r, input int c);
    int b;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_pix   = 8'(pix);
    bus.in_sof   = sof;
    #2;
    b = 0;
    while (!bus.in_ready && b < 100) begin
      @(negedge clk);
      #2;
      b++;
    end
    if (!bus.in_ready) begin
      check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    end else begin
      if (tput_arm && r == 2 && c == 2) t22 = cyc;
      if (r >= 2 && c >= 2) exp_q.push_back(model(r, c));
      @(posedge clk);
    end
    #1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic send_frame(input bit sof_first, input int n_pix);
    for (int i = 0; i < n_pix; i++) begin
      if (gap_en && $urandom_range(0, 3) == 0) @(negedge clk);
      send_pix(img[i / W][i % W], sof_first && i == 0, i / W, i % W);
    end
  endtask

  task automatic wait_drain();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 400) begin
      @(negedge clk);
      b++;
    end
    repeat (4) @(negedge clk);
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_frame(input string name, input bit sof);
    int n0;
    n0 = n_out;
    send_frame(sof, W*H);
    wait_drain();
    check(name, 32'(n_out - n0), 32'((W-2)*(H-2)));
  endtask

  // ---------------- downstream ready ----------------
  int hold_cnt = 0;
  always @(negedge clk) begin
    case (rdy_mode)
      0: bus.out_ready = 1'b1;
      1: bus.out_ready = ($urandom_range(0, 2) != 0);
      default: begin
        if (bus.out_valid && hold_cnt < 3) begin
          bus.out_ready = 1'b0;
          hold_cnt++;
        end else begin
          bus.out_ready = 1'b1;
          hold_cnt = 0;
        end
      end
    endcase
  end

  // ---------------- monitor ----------------
  bit          pv_hold = 1'b0;
  logic [15:0] p_r;
  logic        p_last;
  always @(negedge clk) begin
    logic [16:0] e;
    #2;
    if (rst) begin
      pv_hold = 1'b0;
    end else begin
      if (pv_hold) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_R", 32'(bus.out_R), 32'(p_r));
        check("hold_last", 32'(bus.out_last), 32'(p_last));
      end
      if (bus.out_valid && !bus.out_ready)
        check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'(bus.out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_R", 32'(bus.out_R), 32'(e[15:0]));
          check("out_last", 32'(bus.out_last), 32'(e[16]));
        end
        n_out++;
        if (tput_arm) begin
          if (first_v < 0) first_v = cyc;
          out_cyc.push_back(cyc);
        end
      end
      pv_hold = bus.out_valid && !bus.out_ready;
      p_r     = bus.out_R;
      p_last  = bus.out_last;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 40000", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_pix    = '0;
    bus.in_sof    = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #2;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_R", 32'(bus.out_R), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    fill_frame(0, 0);  run_frame("flat_count", 1'b1);
    fill_frame(1, 0);  run_frame("vstep_count", 1'b0);
    fill_frame(2, 6);  run_frame("diag_count", 1'b1);

    rdy_mode = 2;
    fill_frame(3, 0);  run_frame("hold3_count", 1'b1);
    rdy_mode = 1;
    gap_en   = 1'b1;
    fill_frame(3, 0);  run_frame("random_bp_count", 1'b0);
    rdy_mode = 0;
    gap_en   = 1'b0;

    tput_arm = 1'b1;
    first_v  = -1;
    out_cyc.delete();
    fill_frame(3, 0);  run_frame("tput_count", 1'b1);
    tput_arm = 1'b0;
    check("tput_first_latency", 32'(first_v), 32'(t22 + 3));
    check("tput_result_count", 32'(out_cyc.size()), 32'((W-2)*(H-2)));
    for (int k = 1; k < out_cyc.size(); k++)
      if (k % (W-2) != 0)
        check("tput_one_per_clock", 32'(out_cyc[k] - out_cyc[k-1]), 32'd1);

    // Partial frame cut short by in_sof on a fresh frame
    fill_frame(3, 0);  send_frame(1'b1, 10);
    fill_frame(3, 0);  run_frame("sof_restart_count", 1'b1);

    // Mid-frame reset, then a frame with no in_sof
    fill_frame(3, 0);  send_frame(1'b1, 20);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    fill_frame(3, 0);  run_frame("after_rst_count", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
